// File: rtl/alu_serial.sv
// alu_serial: bit-serial ALU, one result bit per clock, LSB first.
// A single 1-bit slice plus a carry flop executes pass/add/sub/and/or/xor
// on WIDTH-bit operands. The control FSM handshakes with start/busy/done.
// Result and flags are held from done until the next operation completes.
//
// Ports
//   clk        in   1      clock, rising edge
//   reset_n    in   1      asynchronous active-low reset
//   start      in   1      op request, honoured only in IDLE or DONE
//   a, b       in   WIDTH  operands, captured when start is accepted
//   cntrl      in   3      000 pass B, 010 add, 011 sub (A-B), 100 and,
//                          101 or, 110 xor; 001/111 give a zero result
//   busy       out  1      operation in progress
//   done       out  1      one-cycle completion pulse
//   result     out  WIDTH  last completed result
//   negative   out  1      result MSB
//   zero       out  1      result is all zeros
//   overflow   out  1      signed overflow (add/sub only)
//   carry_out  out  1      carry out of MSB (add/sub only; sub: 1 = no borrow)
module alu_serial #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       cntrl,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic             load;
   logic             step;
   logic             last;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] r_next;
   logic [2:0]       op_q;
   logic             carry;
   logic [CNT_W-1:0] count;

   logic             is_sub;
   logic             is_arith;
   logic             b_eff;
   logic             sum_bit;
   logic             carry_next;
   logic             bit_val;

   // State register with registered busy/done decoded from the next state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next == S_RUN);
         done  <= (state_next == S_DONE);
      end
   end

   // Next-state and datapath control strobes
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            step = 1'b1;
            if (count == CNT_W'(WIDTH - 1)) begin
               last       = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               load       = 1'b1;
               state_next = S_RUN;
            end else begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // One-bit slice: subtraction is A + ~B + 1, the +1 preloaded into carry
   always_comb begin
      is_sub     = (op_q == OP_SUB);
      is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
      b_eff      = b_sh[0] ^ is_sub;
      sum_bit    = a_sh[0] ^ b_eff ^ carry;
      carry_next = (a_sh[0] & b_eff) | (carry & (a_sh[0] ^ b_eff));
      case (op_q)
         OP_PASS:        bit_val = b_sh[0];
         OP_ADD, OP_SUB: bit_val = sum_bit;
         OP_AND:         bit_val = a_sh[0] & b_sh[0];
         OP_OR:          bit_val = a_sh[0] | b_sh[0];
         OP_XOR:         bit_val = a_sh[0] ^ b_sh[0];
         default:        bit_val = 1'b0;
      endcase
      // New bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB
      r_next = WIDTH'({bit_val, r_sh} >> 1);
   end

   // Operand shifters, carry, counter and held result/flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_sh      <= '0;
         b_sh      <= '0;
         r_sh      <= '0;
         op_q      <= OP_PASS;
         carry     <= 1'b0;
         count     <= '0;
         result    <= '0;
         negative  <= 1'b0;
         zero      <= 1'b1;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
      end else begin
         if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= cntrl;
            carry <= (cntrl == OP_SUB);
            count <= '0;
         end else if (step) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= r_next;
            carry <= carry_next;
            count <= count + CNT_W'(1);
         end
         // On the final bit, carry still holds the carry into the MSB
         if (last) begin
            result    <= r_next;
            negative  <= r_next[WIDTH-1];
            zero      <= (r_next == '0);
            overflow  <= is_arith & (carry ^ carry_next);
            carry_out <= is_arith & carry_next;
         end
      end
   end

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed bench for alu_serial at WIDTH=8 and WIDTH=64.
module tb_alu_serial;

   localparam logic [2:0] C_PASS = 3'b000;
   localparam logic [2:0] C_ADD  = 3'b010;
   localparam logic [2:0] C_SUB  = 3'b011;
   localparam logic [2:0] C_AND  = 3'b100;
   localparam logic [2:0] C_OR   = 3'b101;
   localparam logic [2:0] C_XOR  = 3'b110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        start;
   logic [7:0]  a, b;
   logic [2:0]  cntrl;
   logic        busy, done, negative, zero, overflow, carry_out;
   logic [7:0]  result;

   logic        start_w;
   logic [63:0] a_w, b_w;
   logic [2:0]  cntrl_w;
   logic        busy_w, done_w, negative_w, zero_w, overflow_w, carry_out_w;
   logic [63:0] result_w;

   int vectors = 0;
   int miscompares = 0;

   alu_serial #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .cntrl(cntrl),
      .busy(busy), .done(done), .result(result), .negative(negative),
      .zero(zero), .overflow(overflow), .carry_out(carry_out)
   );

   alu_serial #(.WIDTH(64)) u_dut64 (
      .clk(clk), .reset_n(reset_n), .start(start_w), .a(a_w), .b(b_w), .cntrl(cntrl_w),
      .busy(busy_w), .done(done_w), .result(result_w), .negative(negative_w),
      .zero(zero_w), .overflow(overflow_w), .carry_out(carry_out_w)
   );

   // Issue one 8-bit op; lat = edges from accepting edge to done (-1 on timeout)
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                         input logic [2:0] ic, output int lat);
      @(posedge clk); #1;
      a = ia; b = ib; cntrl = ic; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_op_w(input logic [63:0] ia, input logic [63:0] ib,
                           input logic [2:0] ic, output int lat);
      @(posedge clk); #1;
      a_w = ia; b_w = ib; cntrl_w = ic; start_w = 1'b1;
      @(posedge clk); #1;
      start_w = 1'b0;
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (done_w) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; a = '0; b = '0; cntrl = '0;
      start_w = 1'b0; a_w = '0; b_w = '0; cntrl_w = '0;
      #12;
      vectors++;
      if ({busy, done, result, negative, zero, overflow, carry_out} !== {2'b00, 8'h00, 4'b0100}) begin
         miscompares++;
         $display("FAIL reset8: got busy=%b done=%b result=%h nzvc=%b%b%b%b, want busy=0 done=0 result=00 nzvc=0100",
                  busy, done, result, negative, zero, overflow, carry_out);
      end
      vectors++;
      if ({busy_w, done_w, result_w, negative_w, zero_w, overflow_w, carry_out_w} !== {2'b00, 64'h0, 4'b0100}) begin
         miscompares++;
         $display("FAIL reset64: got busy=%b done=%b result=%h nzvc=%b%b%b%b, want 0/0/0 nzvc=0100",
                  busy_w, done_w, result_w, negative_w, zero_w, overflow_w, carry_out_w);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_arith();
      logic [7:0] ta [5] = '{8'h05, 8'h03, 8'h05, 8'h7F, 8'hFF};
      logic [7:0] tb [5] = '{8'h03, 8'h05, 8'h05, 8'h01, 8'h01};
      logic [2:0] tc [5] = '{C_ADD, C_SUB, C_SUB, C_ADD, C_ADD};
      logic [7:0] tr [5] = '{8'h08, 8'hFE, 8'h00, 8'h80, 8'h00};
      logic [3:0] tf [5] = '{4'b0000, 4'b1000, 4'b0101, 4'b1010, 4'b0101};
      int lat;
      for (int i = 0; i < 5; i++) begin
         run_op(ta[i], tb[i], tc[i], lat);
         vectors++;
         if (lat !== 8) begin
            miscompares++;
            $display("FAIL arith_latency[%0d]: got %0d edges, want 8", i, lat);
         end
         vectors++;
         if ({result, negative, zero, overflow, carry_out} !== {tr[i], tf[i]}) begin
            miscompares++;
            $display("FAIL arith[%0d] op=%b a=%h b=%h: got result=%h nzvc=%b%b%b%b, want result=%h nzvc=%b",
                     i, tc[i], ta[i], tb[i], result, negative, zero, overflow, carry_out, tr[i], tf[i]);
         end
      end
   endtask

   task automatic test_logic();
      logic [2:0] tc [4] = '{C_AND, C_OR, C_XOR, C_PASS};
      logic [7:0] tr [4] = '{8'h48, 8'hDE, 8'h96, 8'h5C};
      logic [3:0] tf [4] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000};
      int lat;
      for (int i = 0; i < 4; i++) begin
         run_op(8'hCA, 8'h5C, tc[i], lat);
         vectors++;
         if (lat !== 8 || {result, negative, zero, overflow, carry_out} !== {tr[i], tf[i]}) begin
            miscompares++;
            $display("FAIL logic op=%b: got lat=%0d result=%h nzvc=%b%b%b%b, want lat=8 result=%h nzvc=%b",
                     tc[i], lat, result, negative, zero, overflow, carry_out, tr[i], tf[i]);
         end
      end
   endtask

   task automatic test_invalid();
      logic [2:0] tc [2] = '{3'b111, 3'b001};
      logic [7:0] ta [2] = '{8'hFF, 8'h0F};
      logic [7:0] tb [2] = '{8'hFF, 8'hF0};
      int lat;
      for (int i = 0; i < 2; i++) begin
         run_op(ta[i], tb[i], tc[i], lat);
         vectors++;
         if (lat !== 8 || {result, negative, zero, overflow, carry_out} !== {8'h00, 4'b0100}) begin
            miscompares++;
            $display("FAIL invalid op=%b: got lat=%0d result=%h nzvc=%b%b%b%b, want lat=8 result=00 nzvc=0100",
                     tc[i], lat, result, negative, zero, overflow, carry_out);
         end
      end
   endtask

   task automatic test_ignore_start();
      int pulses = 0;
      int first = -1;
      logic [7:0] res_at_done = '0;
      @(posedge clk); #1;
      a = 8'h05; b = 8'h03; cntrl = C_ADD; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      a = 8'h11; b = 8'h22; cntrl = C_XOR; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = '0; b = '0; cntrl = C_PASS;
      for (int k = 4; k <= 30; k++) begin
         @(posedge clk); #1;
         if (done) begin
            pulses++;
            if (first < 0) begin
               first = k;
               res_at_done = result;
            end
         end
      end
      vectors++;
      if (pulses !== 1 || first !== 8) begin
         miscompares++;
         $display("FAIL ignore_start_done: got %0d pulses first at edge %0d, want 1 pulse at edge 8", pulses, first);
      end
      vectors++;
      if (res_at_done !== 8'h08 || result !== 8'h08) begin
         miscompares++;
         $display("FAIL ignore_start_result: got %h (now %h), want 08", res_at_done, result);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_done, exp_busy;
      logic [7:0] exp_res;
      @(posedge clk); #1;
      a = 8'h01; b = 8'h02; cntrl = C_ADD; start = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 27; k++) begin
         @(posedge clk); #1;
         exp_done = (k == 8) || (k == 17) || (k == 26);
         exp_busy = (k < 26) && !exp_done;
         vectors++;
         if ({busy, done} !== {exp_busy, exp_done}) begin
            miscompares++;
            $display("FAIL b2b_handshake k=%0d: got busy=%b done=%b, want busy=%b done=%b",
                     k, busy, done, exp_busy, exp_done);
         end
         if (exp_done || k == 12) begin
            exp_res = (k == 8 || k == 12) ? 8'h03 : (k == 17) ? 8'h30 : 8'h41;
            vectors++;
            if (result !== exp_res) begin
               miscompares++;
               $display("FAIL b2b_result k=%0d: got %h, want %h", k, result, exp_res);
            end
         end
         if (k == 2)  begin a = 8'h10; b = 8'h20; end
         if (k == 11) begin a = 8'h40; b = 8'h01; end
         if (k == 20) start = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      int lat;
      @(posedge clk); #1;
      a = 8'h7F; b = 8'h01; cntrl = C_ADD; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, result, negative, zero, overflow, carry_out} !== {2'b00, 8'h00, 4'b0100}) begin
         miscompares++;
         $display("FAIL reset_mid: got busy=%b done=%b result=%h nzvc=%b%b%b%b, want 0/0/00 nzvc=0100",
                  busy, done, result, negative, zero, overflow, carry_out);
      end
      #20;
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      vectors++;
      if (pulses !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_quiet: got %0d active cycles after reset, want 0", pulses);
      end
      run_op(8'h05, 8'h03, C_ADD, lat);
      vectors++;
      if (lat !== 8 || result !== 8'h08 || {negative, zero, overflow, carry_out} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_mid_recover: got lat=%0d result=%h nzvc=%b%b%b%b, want lat=8 result=08 nzvc=0000",
                  lat, result, negative, zero, overflow, carry_out);
      end
   endtask

   task automatic test_wide();
      logic [63:0] ta [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0};
      logic [63:0] tb [3] = '{64'h1, 64'h1, 64'h1};
      logic [2:0]  tc [3] = '{C_ADD, C_ADD, C_SUB};
      logic [63:0] tr [3] = '{64'h0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
      logic [3:0]  tf [3] = '{4'b0101, 4'b1010, 4'b1000};
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_op_w(ta[i], tb[i], tc[i], lat);
         vectors++;
         if (lat !== 64 || {result_w, negative_w, zero_w, overflow_w, carry_out_w} !== {tr[i], tf[i]}) begin
            miscompares++;
            $display("FAIL wide[%0d]: got lat=%0d result=%h nzvc=%b%b%b%b, want lat=64 result=%h nzvc=%b",
                     i, lat, result_w, negative_w, zero_w, overflow_w, carry_out_w, tr[i], tf[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_logic();
      test_invalid();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_wide();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
